// File: rtl/wave_phase_gen_pkg.sv
// rtl/wave_phase_gen_pkg.sv - shared widths and state encoding for the phase generator
package wave_pkg;

    localparam int WAVE_ACC_W  = 16;
    localparam int WAVE_ADDR_W = 8;
    localparam int WAVE_DIV_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wave_state_t;

endpackage

// File: rtl/wave_phase_gen_if.sv
// rtl/wave_phase_gen_if.sv - control/address bundle of the phase generator (WAVE_PHASE_OFFSET_EN adds phase_offset)
interface wave_phase_gen_if
    import wave_pkg::*;
#(
    parameter int ACC_W  = WAVE_ACC_W,
    parameter int ADDR_W = WAVE_ADDR_W,
    parameter int DIV_W  = WAVE_DIV_W
);

    logic              enable;
    logic              oneshot;
    logic [ACC_W-1:0]  tuning_word;
    logic              tw_load;
    logic [DIV_W-1:0]  tick_div;
`ifdef WAVE_PHASE_OFFSET_EN
    logic [ACC_W-1:0]  phase_offset;
`endif
    logic [ADDR_W-1:0] address;
    logic              sample_valid;
    logic              wrap;
    logic              busy;
    logic              done;

    modport master (
        output enable, oneshot, tuning_word, tw_load, tick_div,
`ifdef WAVE_PHASE_OFFSET_EN
        output phase_offset,
`endif
        input  address, sample_valid, wrap, busy, done
    );

    modport slave (
        input  enable, oneshot, tuning_word, tw_load, tick_div,
`ifdef WAVE_PHASE_OFFSET_EN
        input  phase_offset,
`endif
        output address, sample_valid, wrap, busy, done
    );

endinterface

// File: rtl/wave_phase_gen_tick_div.sv
// rtl/wave_phase_gen_tick_div.sv - sample-rate prescaler producing one step per tick_div+1 clocks
module wave_tick_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             clr,
    input  logic [DIV_W-1:0] tick_div,
    output logic             step
);

    logic [DIV_W-1:0] div_cnt;

    // tick_div is compared live; if it drops below div_cnt the counter free-runs to all-ones and rolls over
    assign step = !clr && (div_cnt == tick_div);

    // prescaler counter: held at zero while cleared, restarts on terminal count
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            div_cnt <= '0;
        end else if (clr || (div_cnt == tick_div)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wave_phase_gen.sv
// rtl/wave_phase_gen.sv - phase-accumulator ROM address generator (WAVE_PHASE_OFFSET_EN adds a live phase offset)
module wave_phase_gen
    import wave_pkg::*;
#(
    parameter int ACC_W  = WAVE_ACC_W,
    parameter int ADDR_W = WAVE_ADDR_W,
    parameter int DIV_W  = WAVE_DIV_W
) (
    input  logic            clk,
    input  logic            n_reset,
    wave_phase_gen_if.slave bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]        state;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  tw_q;
    logic              os_q;
    logic [ADDR_W-1:0] address_q;
    logic              sample_valid_q;
    logic              wrap_q;
    logic              step;
    logic              div_clr;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  addr_full;
    logic [ADDR_W-1:0] step_addr;
    logic [ADDR_W-1:0] entry_addr;

    // the prescaler only counts while running and enabled, so a pending step is dropped on disable
    assign div_clr = (state != ST_RUN) || !bus.enable;

    wave_tick_div #(.DIV_W(DIV_W)) u_tick_div (
        .clk      (clk),
        .n_reset  (n_reset),
        .clr      (div_clr),
        .tick_div (bus.tick_div),
        .step     (step)
    );

    // carry out of the accumulator alone decides wrap and one-shot termination
    assign sum = {1'b0, acc} + {1'b0, tw_q};

`ifdef WAVE_PHASE_OFFSET_EN
    assign addr_full  = sum[ACC_W-1:0] + bus.phase_offset;
    assign entry_addr = ADDR_W'(bus.phase_offset >> (ACC_W - ADDR_W));
`else
    assign addr_full  = sum[ACC_W-1:0];
    assign entry_addr = '0;
`endif
    assign step_addr = ADDR_W'(addr_full >> (ACC_W - ADDR_W));

    assign bus.address      = address_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.wrap         = wrap_q;
    assign bus.busy         = (state == ST_RUN);
    assign bus.done         = (state == ST_DONE);

    // run-control FSM, accumulator and registered address/strobes
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state          <= ST_IDLE;
            acc            <= '0;
            tw_q           <= '0;
            os_q           <= 1'b0;
            address_q      <= '0;
            sample_valid_q <= 1'b0;
            wrap_q         <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            wrap_q         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.tw_load || bus.enable) begin
                        tw_q <= bus.tuning_word;
                    end
                    if (bus.enable) begin
                        state     <= ST_RUN;
                        os_q      <= bus.oneshot;
                        acc       <= '0;
                        address_q <= entry_addr;
                    end
                end
                ST_RUN: begin
                    if (!bus.enable) begin
                        state     <= ST_IDLE;
                        acc       <= '0;
                        address_q <= '0;
                    end else begin
                        if (bus.tw_load) begin
                            tw_q <= bus.tuning_word;
                        end
                        if (step) begin
                            acc    <= sum[ACC_W-1:0];
                            wrap_q <= sum[ACC_W];
                            if (sum[ACC_W] && os_q) begin
                                state <= ST_DONE;
                            end else begin
                                address_q      <= step_addr;
                                sample_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.enable) begin
                        state     <= ST_IDLE;
                        acc       <= '0;
                        address_q <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
